// File: rtl/sipo_deserializer_if.sv
// Bundle of the serial receive inputs and parallel word outputs of sipo_deserializer.
// The transmitter-side driver uses the master view; the deserializer uses the slave view.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic             dir;
  logic             bit_valid;
  logic             serial_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic [CW-1:0]    bit_count;
  logic             frame_err;

  modport master (
    output start, dir, bit_valid, serial_in,
    input  data_out, data_valid, busy, bit_count, frame_err
  );

  modport slave (
    input  start, dir, bit_valid, serial_in,
    output data_out, data_valid, busy, bit_count, frame_err
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: frames words with start, assembles MSB- or LSB-first,
// pulses data_valid on completion and frame_err on restart or inter-bit timeout.
module sipo_deserializer #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sipo_deserializer_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shift_in_s;

  // Candidate shift register contents if the current serial bit is accepted.
  always_comb begin
    shift_in_s = shift_q;
    if (dir_q) begin
      shift_in_s = {bus.serial_in, shift_q[WIDTH-1:1]};
    end else begin
      shift_in_s = {shift_q[WIDTH-2:0], bus.serial_in};
    end
  end

  // Next-state and output computation; start always takes priority over a concurrent bit.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    dir_d        = dir_q;
    bit_count_d  = bit_count_q;
    tmo_d        = tmo_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RECV;
          dir_d       = bus.dir;
          shift_d     = '0;
          bit_count_d = '0;
          tmo_d       = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (bus.start) begin
          frame_err_d = 1'b1;
          dir_d       = bus.dir;
          shift_d     = '0;
          bit_count_d = '0;
          tmo_d       = '0;
        end else if (bus.bit_valid) begin
          tmo_d = '0;
          if (bit_count_q == CNT_LAST) begin
            data_out_d   = shift_in_s;
            data_valid_d = 1'b1;
            shift_d      = '0;
            bit_count_d  = '0;
            state_d      = IDLE;
          end else begin
            shift_d     = shift_in_s;
            bit_count_d = bit_count_q + CW'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          // Inter-bit gap reached TIMEOUT cycles: drop the partial word.
          frame_err_d = 1'b1;
          shift_d     = '0;
          bit_count_d = '0;
          tmo_d       = '0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        shift_d     = '0;
        bit_count_d = '0;
        tmo_d       = '0;
      end
    endcase
    busy_d = (state_d == RECV);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      dir_q        <= 1'b0;
      bit_count_q  <= '0;
      tmo_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      dir_q        <= dir_d;
      bit_count_q  <= bit_count_d;
      tmo_q        <= tmo_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = busy_q;
  assign bus.bit_count  = bit_count_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (WIDTH=4, TIMEOUT=16).
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
module tb_sipo_deserializer;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sipo_deserializer_if #(.WIDTH(4)) bus ();

  sipo_deserializer #(.WIDTH(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1;
    bus.serial_in = b;
    step();
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b0;
  endtask

  task automatic do_start(input logic d);
    bus.start = 1'b1;
    bus.dir   = d;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.dir       = 1'b0;
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_data_valid", 32'(bus.data_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_bit_count", 32'(bus.bit_count), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);

    // MSB-first 1,0,1,0
    do_start(1'b0);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    chk("t1_cnt0", 32'(bus.bit_count), 32'h0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t1_cnt3", 32'(bus.bit_count), 32'h3);
    chk("t1_dv_early", 32'(bus.data_valid), 32'h0);
    send_bit(1'b0);
    chk("t1_data", 32'(bus.data_out), 32'hA);
    chk("t1_dv", 32'(bus.data_valid), 32'h1);
    chk("t1_busy_fall", 32'(bus.busy), 32'h0);
    chk("t1_cnt_clr", 32'(bus.bit_count), 32'h0);
    chk("t1_ferr", 32'(bus.frame_err), 32'h0);
    step();
    chk("t1_dv_pulse", 32'(bus.data_valid), 32'h0);
    chk("t1_hold", 32'(bus.data_out), 32'hA);

    // LSB-first 0,1,0,1 with dir toggling mid-frame
    do_start(1'b1);
    bus.dir = 1'b0;
    send_bit(1'b0);
    bus.dir = 1'b1;
    send_bit(1'b1);
    bus.dir = 1'b0;
    send_bit(1'b0);
    bus.dir = 1'b1;
    send_bit(1'b1);
    chk("t2_data", 32'(bus.data_out), 32'hA);
    chk("t2_dv", 32'(bus.data_valid), 32'h1);
    step();

    // Gapped MSB-first 1,1,0,0 with 3-cycle gaps
    do_start(1'b0);
    send_bit(1'b1);
    step(); step(); step();
    send_bit(1'b1);
    step(); step(); step();
    chk("t3_gap_busy", 32'(bus.busy), 32'h1);
    chk("t3_gap_cnt", 32'(bus.bit_count), 32'h2);
    send_bit(1'b0);
    step(); step(); step();
    chk("t3_gap_dv", 32'(bus.data_valid), 32'h0);
    send_bit(1'b0);
    chk("t3_data", 32'(bus.data_out), 32'hC);
    chk("t3_dv", 32'(bus.data_valid), 32'h1);
    step();
    chk("t3_dv_pulse", 32'(bus.data_valid), 32'h0);
    step(); step(); step();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t3_stray_busy", 32'(bus.busy), 32'h0);
    chk("t3_stray_cnt", 32'(bus.bit_count), 32'h0);
    chk("t3_stray_dv", 32'(bus.data_valid), 32'h0);
    chk("t3_stray_ferr", 32'(bus.frame_err), 32'h0);
    chk("t3_hold", 32'(bus.data_out), 32'hC);

    // Restart after 2 bits (concurrent bit dropped), then 0,1,1,0
    do_start(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.bit_valid = 1'b1;
    bus.serial_in = 1'b1;
    do_start(1'b0);
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b0;
    chk("t4_ferr", 32'(bus.frame_err), 32'h1);
    chk("t4_busy", 32'(bus.busy), 32'h1);
    chk("t4_cnt", 32'(bus.bit_count), 32'h0);
    chk("t4_dv", 32'(bus.data_valid), 32'h0);
    chk("t4_keep", 32'(bus.data_out), 32'hC);
    send_bit(1'b0);
    chk("t4_ferr_pulse", 32'(bus.frame_err), 32'h0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t4_data", 32'(bus.data_out), 32'h6);
    chk("t4_dv2", 32'(bus.data_valid), 32'h1);
    step();

    // start coincident with the 4th bit: abort wins
    do_start(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.bit_valid = 1'b1;
    bus.serial_in = 1'b1;
    do_start(1'b0);
    bus.bit_valid = 1'b0;
    bus.serial_in = 1'b0;
    chk("t4b_ferr", 32'(bus.frame_err), 32'h1);
    chk("t4b_dv", 32'(bus.data_valid), 32'h0);
    chk("t4b_keep", 32'(bus.data_out), 32'h6);
    chk("t4b_busy", 32'(bus.busy), 32'h1);

    // Timeout: 1 bit then 16 idle cycles
    send_bit(1'b1);
    chk("t5_cnt1", 32'(bus.bit_count), 32'h1);
    for (int i = 0; i < 15; i++) step();
    chk("t5_busy15", 32'(bus.busy), 32'h1);
    chk("t5_ferr15", 32'(bus.frame_err), 32'h0);
    step();
    chk("t5_ferr", 32'(bus.frame_err), 32'h1);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_cnt", 32'(bus.bit_count), 32'h0);
    chk("t5_keep", 32'(bus.data_out), 32'h6);
    chk("t5_dv", 32'(bus.data_valid), 32'h0);
    step();
    chk("t5_ferr_pulse", 32'(bus.frame_err), 32'h0);

    // Reset mid-frame, then MSB-first 1,0,0,1
    do_start(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_data", 32'(bus.data_out), 32'h0);
    chk("t6_dv", 32'(bus.data_valid), 32'h0);
    chk("t6_busy", 32'(bus.busy), 32'h0);
    chk("t6_cnt", 32'(bus.bit_count), 32'h0);
    chk("t6_ferr", 32'(bus.frame_err), 32'h0);
    do_start(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t6_data2", 32'(bus.data_out), 32'h9);
    chk("t6_dv2", 32'(bus.data_valid), 32'h1);
    step();
    chk("t6_hold", 32'(bus.data_out), 32'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Receive end of the 4-bit load/shift register link: it reassembles a serial bit stream from a PISO shifter into a parallel word.
- A `start` strobe frames each word.
- Each `bit_valid` strobe samples `serial_in`.
- The `dir` bit selects MSB-first or LSB-first assembly, matching the transmitter's shift direction.
- Reports completed words with a one-cycle `data_valid` pulse, and aborted frames with `frame_err`.

Parameters:
- WIDTH, 4, word length in bits (≥2).
- TIMEOUT, 16, max clk cycles allowed between accepted bits inside a frame before abort (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new frame; sampled every cycle.
- dir  input  1  0 = MSB-first (shift left, new bit into bit 0); 1 = LSB-first (shift right, new bit into bit WIDTH-1); latched on start.
- bit_valid  input  1  `serial_in` holds a valid bit this cycle.
- serial_in  input  1  serial data bit.
- data_out  output  WIDTH  last completed word; held until the next completion.
- data_valid  output  1  one-cycle pulse: `data_out` was updated this cycle.
- busy  output  1  high while in RECV.
- bit_count  output  $clog2(WIDTH+1)  bits accepted in the current frame.
- frame_err  output  1  one-cycle pulse: frame aborted.

Behaviour:

Reset (`rst` high at a clk edge):
- state=IDLE.
- `data_out`, `data_valid`, `busy`, `bit_count`, `frame_err`, internal shift register, latched dir and timeout counter all cleared to 0.
- `rst` overrides every other input, including mid-frame; the partial word is discarded and no `frame_err` is raised.

FSM states: IDLE, RECV.
- IDLE, `start`=1 → RECV:
  - latch `dir`;
  - clear shift reg, `bit_count` and timeout counter;
  - a `bit_valid` in the same cycle as `start` is NOT captured.
- IDLE, `bit_valid` without `start`: ignored; no state change, no error.
- RECV, `bit_valid`=1, `start`=0:
  - shift in `serial_in` per the latched dir;
  - `bit_count`+1;
  - timeout counter cleared.
- RECV, final bit (`bit_count`==WIDTH-1 and `bit_valid`):
  - next cycle, `data_out` = assembled word and `data_valid`=1 for exactly one cycle;
  - state → IDLE, `bit_count` → 0.
  - Latency: `data_valid` rises one clk after the last bit is sampled.
- RECV, `start`=1 (with or without `bit_valid`): abort and restart.
  - `frame_err` pulses next cycle;
  - dir re-latched, count and shift reg cleared, stay in RECV;
  - the concurrent bit is not captured;
  - `data_out` unchanged.
- RECV, no `bit_valid` for TIMEOUT consecutive cycles:
  - `frame_err` pulses next cycle;
  - state → IDLE, count cleared, `data_out` unchanged.
  - The counter starts from the cycle after entry or after the last accepted bit.
- `start` in the same cycle as the final bit: start wins (abort rule); no `data_valid`.
- `dir` changes mid-frame: ignored until the next `start`.
- `data_valid` and `frame_err` are never high in the same cycle.
- `busy` = (state==RECV), registered.

Test Plan:
- Reset, then `start` with `dir`=0 and bits 1,0,1,0 on consecutive `bit_valid` cycles → one cycle after the 4th bit: `data_out`=4'b1010, `data_valid`=1 for one cycle, `busy` falls, `bit_count`=0.
- `start` with `dir`=1 and bits 0,1,0,1 (LSB-first of 1010) → `data_out`=4'b1010; toggling `dir` mid-frame does not change the result.
- Gapped `bit_valid` (idle gaps of 3 cycles, TIMEOUT=16) with bits 1,1,0,0 MSB-first → `data_out`=4'b1100, `data_valid` one pulse; `data_out` then holds 1100 through an idle period and through stray `bit_valid` in IDLE.
- `start`, 2 bits, then `start` again and 4 bits 0,1,1,0 → `frame_err` pulse after the second `start`, then `data_out`=4'b0110; also `start` coincident with the 4th bit → `frame_err`, no `data_valid`, `data_out` keeps its old value.
- `start`, 1 bit, then 16 idle cycles → `frame_err` pulses, `busy`=0, `bit_count`=0, `data_out` unchanged.
- `rst` asserted after 3 bits of a frame → next cycle all outputs 0, no `frame_err`; a subsequent full frame 1001 MSB-first yields `data_out`=4'b1001.
